audio_src_sched: RTL and testbench



---
 rtl/audio_src_sched.sv | 213 +++++++++++++++++++++
 tb/tb_audio_src_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_src_sched.sv
// Sample-source scheduler feeding the sampler: one DAC code per tick from synth, PCM FIFO, mix or mute.
// Build option: define AUDIO_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of muting.
module audio_src_sched #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     synth_valid_in,
  input  logic [CODE_W-1:0]        synth_code_in,
  output logic                     synth_ready_out,
  input  logic                     pcm_wr_valid,
  input  logic [CODE_W-1:0]        pcm_wr_data,
  output logic                     pcm_wr_ready,
  input  logic [1:0]               src_sel,
  input  logic                     tick,
  output logic                     smp_valid,
  output logic [CODE_W-1:0]        smp_code,
  output logic [15:0]              underrun_cnt,
  input  logic                     underrun_clr,
  output logic [$clog2(DEPTH):0]   pcm_level,
  output logic                     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Handshakes: a transfer occurs on any cycle where valid and ready are both high;
  // ready never depends on valid, and both readies are forced low while rst is high.

  logic              synth_full_q, synth_full_d;
  logic [CODE_W-1:0] synth_data_q, synth_data_d;
  logic              synth_push, synth_pop;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              pcm_push, pcm_pop;
  logic [CODE_W-1:0] pcm_head;

  // Source selection and availability are frozen at the tick cycle so that
  // writes landing on that same edge cannot satisfy the commit.
  logic [1:0]        sel_q, sel_d;
  logic              s_av_q, s_av_d;
  logic              p_av_q, p_av_d;

  logic              smp_valid_q, smp_valid_d;
  logic [CODE_W-1:0] smp_code_q, smp_code_d;
  logic [15:0]       ucnt_q, ucnt_d;
  logic              underrun;

  logic [CODE_W:0]   mix_sum;
  logic [CODE_W-1:0] mix_code;

  assign synth_ready_out = !synth_full_q && !rst;
  assign pcm_wr_ready    = (level_q != LW'(DEPTH)) && !rst;
  assign synth_push      = synth_valid_in && synth_ready_out;
  assign pcm_push        = pcm_wr_valid && pcm_wr_ready;
  assign pcm_head        = mem_q[rd_ptr_q];

  assign mix_sum  = {1'b0, synth_data_q} + {1'b0, pcm_head};
  assign mix_code = CODE_W'(mix_sum >> 1);

  assign smp_valid    = smp_valid_q;
  assign smp_code     = smp_code_q;
  assign underrun_cnt = ucnt_q;
  assign pcm_level    = level_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    s_av_d      = s_av_q;
    p_av_d      = p_av_q;
    smp_valid_d = smp_valid_q;
    smp_code_d  = smp_code_q;
    synth_pop   = 1'b0;
    pcm_pop     = 1'b0;
    underrun    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_COMMIT;
          sel_d   = src_sel;
          s_av_d  = synth_full_q;
          p_av_d  = (level_q != '0);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        case (sel_q)
          2'd0: begin
            smp_valid_d = 1'b0;
            smp_code_d  = '0;
          end
          2'd1: begin
            if (s_av_q) begin
              smp_valid_d = 1'b1;
              smp_code_d  = synth_data_q;
              synth_pop   = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end
          2'd2: begin
            if (p_av_q) begin
              smp_valid_d = 1'b1;
              smp_code_d  = pcm_head;
              pcm_pop     = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end
          default: begin
            if (s_av_q && p_av_q) begin
              smp_valid_d = 1'b1;
              smp_code_d  = mix_code;
              synth_pop   = 1'b1;
              pcm_pop     = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end
        endcase
        if (underrun) begin
`ifdef AUDIO_UNDERRUN_HOLD_EN
          smp_valid_d = smp_valid_q;
          smp_code_d  = smp_code_q;
`else
          smp_valid_d = 1'b0;
          smp_code_d  = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    synth_full_d = synth_full_q;
    synth_data_d = synth_data_q;
    if (synth_pop) begin
      synth_full_d = 1'b0;
    end
    if (synth_push) begin
      synth_full_d = 1'b1;
      synth_data_d = synth_code_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(pcm_push);
    rd_ptr_d = rd_ptr_q + AW'(pcm_pop);
    level_d  = level_q + LW'(pcm_push) - LW'(pcm_pop);
  end

  // Clear beats a coincident increment.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
    if (underrun_clr) begin
      ucnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      s_av_q       <= 1'b0;
      p_av_q       <= 1'b0;
      synth_full_q <= 1'b0;
      synth_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      smp_valid_q  <= 1'b0;
      smp_code_q   <= '0;
      ucnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      s_av_q       <= s_av_d;
      p_av_q       <= p_av_d;
      synth_full_q <= synth_full_d;
      synth_data_q <= synth_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      smp_valid_q  <= smp_valid_d;
      smp_code_q   <= smp_code_d;
      ucnt_q       <= ucnt_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (pcm_push) begin
      mem_q[wr_ptr_q] <= pcm_wr_data;
    end
  end

endmodule

// File: tb/tb_audio_src_sched.sv
// Randomized scoreboard bench for audio_src_sched against a queue-based reference model.
module tb_audio_src_sched;

  localparam int DEPTH  = 8;
  localparam int CODE_W = 10;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              synth_valid_in = 1'b0;
  logic [CODE_W-1:0] synth_code_in = '0;
  logic              synth_ready_out;
  logic              pcm_wr_valid = 1'b0;
  logic [CODE_W-1:0] pcm_wr_data = '0;
  logic              pcm_wr_ready;
  logic [1:0]        src_sel = 2'd0;
  logic              tick = 1'b0;
  logic              smp_valid;
  logic [CODE_W-1:0] smp_code;
  logic [15:0]       underrun_cnt;
  logic              underrun_clr = 1'b0;
  logic [LW-1:0]     pcm_level;
  logic              dbg_state;

  audio_src_sched #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst(rst),
    .synth_valid_in(synth_valid_in), .synth_code_in(synth_code_in),
    .synth_ready_out(synth_ready_out),
    .pcm_wr_valid(pcm_wr_valid), .pcm_wr_data(pcm_wr_data), .pcm_wr_ready(pcm_wr_ready),
    .src_sel(src_sel), .tick(tick),
    .smp_valid(smp_valid), .smp_code(smp_code),
    .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr),
    .pcm_level(pcm_level), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {valid, code, underrun_cnt} per tick
  logic [26:0] exp_q[$];

  int   pcm_m[$];
  int   synth_m[$];
  int   cnt_m  = 0;
  logic prev_v = 1'b0;
  int   prev_c = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_commit(input logic [1:0] sel, input logic clr);
    logic under;
    int   s, p;
    under = 1'b0;
    case (sel)
      2'd0: begin prev_v = 1'b0; prev_c = 0; end
      2'd1: begin
        if (synth_m.size() > 0) begin prev_v = 1'b1; prev_c = synth_m.pop_front(); end
        else under = 1'b1;
      end
      2'd2: begin
        if (pcm_m.size() > 0) begin prev_v = 1'b1; prev_c = pcm_m.pop_front(); end
        else under = 1'b1;
      end
      default: begin
        if (synth_m.size() > 0 && pcm_m.size() > 0) begin
          s = synth_m.pop_front();
          p = pcm_m.pop_front();
          prev_v = 1'b1;
          prev_c = (s + p) / 2;
        end else under = 1'b1;
      end
    endcase
    if (under) begin
`ifndef AUDIO_UNDERRUN_HOLD_EN
      prev_v = 1'b0;
      prev_c = 0;
`endif
      if (cnt_m < 65535) cnt_m++;
    end
    if (clr) cnt_m = 0;
    exp_q.push_back({prev_v, prev_c[CODE_W-1:0], cnt_m[15:0]});
  endtask

  task automatic pcm_write(input int d);
    check("pcm_wr_ready", pcm_wr_ready, pcm_m.size() != DEPTH);
    if (pcm_m.size() < DEPTH) pcm_m.push_back(d);
    pcm_wr_valid = 1'b1;
    pcm_wr_data  = d[CODE_W-1:0];
    @(negedge clk);
    pcm_wr_valid = 1'b0;
  endtask

  task automatic synth_write(input int d);
    check("synth_ready_out", synth_ready_out, synth_m.size() == 0);
    if (synth_m.size() == 0) synth_m.push_back(d);
    synth_valid_in = 1'b1;
    synth_code_in  = d[CODE_W-1:0];
    @(negedge clk);
    synth_valid_in = 1'b0;
  endtask

  task automatic do_tick(input logic [1:0] sel, input logic clr);
    model_commit(sel, clr);
    src_sel = sel;
    tick    = 1'b1;
    @(negedge clk);
    tick         = 1'b0;
    underrun_clr = clr;
    @(negedge clk);
    underrun_clr = 1'b0;
    @(negedge clk);
    check("pcm_level", pcm_level, pcm_m.size());
    check("synth_ready_after", synth_ready_out, synth_m.size() == 0);
  endtask

  task automatic tick_then_reset();
    exp_q.push_back(27'd0);
    src_sel = 2'd2;
    tick    = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pcm_m.delete();
    synth_m.delete();
    cnt_m  = 0;
    prev_v = 1'b0;
    prev_c = 0;
    @(negedge clk);
    check("rst_level", pcm_level, 0);
    check("rst_valid", smp_valid, 0);
    check("rst_cnt", underrun_cnt, 0);
  endtask

  // Monitor: each accepted tick yields one committed output two edges later.
  initial begin
    logic [26:0] e;
    forever begin
      @(posedge clk);
      if (tick && !rst) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=commit expected=none");
        end else begin
          e = exp_q.pop_front();
          check("smp_valid", smp_valid, e[26]);
          check("smp_code", smp_code, e[25:16]);
          check("underrun_cnt", underrun_cnt, e[15:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    check("rst_synth_ready", synth_ready_out, 0);
    check("rst_pcm_ready", pcm_wr_ready, 0);
    check("rst_smp_valid", smp_valid, 0);
    check("rst_smp_code", smp_code, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_pcm_level", pcm_level, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_synth_ready", synth_ready_out, 1);
    check("post_rst_pcm_ready", pcm_wr_ready, 1);

    pcm_write(10'h3FF);
    pcm_write(10'h001);
    check("level_two", pcm_level, 2);
    do_tick(2'd2, 1'b0);
    do_tick(2'd2, 1'b0);

    synth_write(10'h3FF);
    pcm_write(10'h3FE);
    do_tick(2'd3, 1'b0);

    repeat (3) do_tick(2'd1, 1'b0);

    for (int i = 0; i < DEPTH + 1; i++) pcm_write(10'h100 + i * 7);
    check("full_level", pcm_level, DEPTH);
    repeat (DEPTH) do_tick(2'd2, 1'b0);

    pcm_write(10'h055);
    do_tick(2'd3, 1'b0);
    do_tick(2'd2, 1'b0);

    for (int i = 0; i < 4; i++) pcm_write(10'h200 + i);
    check("level_four", pcm_level, 4);
    tick_then_reset();

    do_tick(2'd1, 1'b0);
    do_tick(2'd2, 1'b1);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 1: pcm_write($urandom_range(0, 1023));
        2: synth_write($urandom_range(0, 1023));
        default: do_tick(2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      endcase
    end

    repeat (4) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
